// File: rtl/signal_modulator.sv
// signal_modulator -- BPSK frame transmitter: alternating preamble, LSB-first data word, silent guard symbol.
// Revision 1.0
`default_nettype none

module signal_modulator #(
  parameter int DATA_WIDTH         = 12,
  parameter int PACKET_SIZE        = 8,
  parameter int SAMPLES_PER_SYMBOL = 16,
  parameter int PREAMBLE_BITS      = 8,
  parameter int AMPLITUDE          = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PACKET_SIZE-1:0]       data_in,
  input  logic                         data_valid,
  output logic                         data_ready,
  output logic signed [DATA_WIDTH-1:0] signal,
  output logic                         busy,
  output logic                         symbol_strobe
);

  localparam int SCW  = $clog2(SAMPLES_PER_SYMBOL);
  localparam int MAXB = (PREAMBLE_BITS > PACKET_SIZE) ? PREAMBLE_BITS : PACKET_SIZE;
  localparam int BCW  = $clog2(MAXB + 1);

  localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [BCW-1:0] PRE_LAST    = BCW'(PREAMBLE_BITS - 1);
  localparam logic [BCW-1:0] DATA_LAST   = BCW'(PACKET_SIZE - 1);

  localparam logic signed [DATA_WIDTH-1:0] AMP_POS = DATA_WIDTH'(AMPLITUDE);
  localparam logic signed [DATA_WIDTH-1:0] AMP_NEG = -AMP_POS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GUARD    = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [SCW-1:0]                 sample_q, sample_d;
  logic [BCW-1:0]                 bit_q, bit_d;
  logic [PACKET_SIZE-1:0]         shreg_q, shreg_d;
  logic signed [DATA_WIDTH-1:0]   signal_q, signal_d;
  logic                           strobe_q, strobe_d;

  logic                           sym_bit;
  logic                           sample_last;
  logic signed [DATA_WIDTH-1:0]   mod_sample;

  // Preamble alternates 1,0,1,... so the symbol bit is the inverted LSB of the symbol index.
  always_comb begin
    sym_bit = (state_q == ST_DATA) ? shreg_q[0] : ~bit_q[0];
  end

  assign sample_last = (sample_q == SAMPLE_LAST);

  // Carrier 0,+A,0,-A on phase = sample mod 4; a '1' symbol swaps the sign of the nonzero phases.
  always_comb begin
    mod_sample = '0;
    if (sample_q[0]) begin
      mod_sample = (sample_q[1] ^ sym_bit) ? AMP_NEG : AMP_POS;
    end
  end

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    signal_d = '0;
    strobe_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_valid && data_ready) begin
          shreg_d  = data_in;
          sample_d = '0;
          bit_d    = '0;
          state_d  = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        signal_d = mod_sample;
        strobe_d = (sample_q == '0);
        sample_d = sample_q + SCW'(1);
        if (sample_last) begin
          sample_d = '0;
          if (bit_q == PRE_LAST) begin
            bit_d   = '0;
            state_d = ST_DATA;
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end

      ST_DATA: begin
        signal_d = mod_sample;
        strobe_d = (sample_q == '0);
        sample_d = sample_q + SCW'(1);
        if (sample_last) begin
          sample_d = '0;
          shreg_d  = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = ST_GUARD;
          end else begin
            bit_d = bit_q + BCW'(1);
          end
        end
      end

      ST_GUARD: begin
        sample_d = sample_q + SCW'(1);
        if (sample_last) begin
          sample_d = '0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        sample_d = '0;
        bit_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      signal_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      signal_q <= signal_d;
      strobe_q <= strobe_d;
    end
  end

  assign data_ready    = (state_q == ST_IDLE) && !rst;
  assign busy          = (state_q != ST_IDLE);
  assign signal        = signal_q;
  assign symbol_strobe = strobe_q;

endmodule

`default_nettype wire
